alu_rs: RTL

Reservation station feeding the LC-3b ALU in the out-of-order core. It accepts dispatched ALU instructions from decode, holds them until both operands are available, and snoops the common data bus (CDB) to capture operand values. It then issues the oldest ready instruction to the combinational ALU. The ALU result is presented to the CDB arbiter through a valid/ready handshake.

---
 rtl/alu_rs.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the LC-3b ALU.
//
// Holds up to ENTRIES dispatched ALU instructions. It snoops the CDB to capture
// pending operands. Each cycle it moves the oldest fully-ready instruction into a
// single registered exec slot that drives the combinational ALU. The ALU result
// is offered to the CDB arbiter with a valid/ready handshake.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               squash every entry and the exec slot at the next edge
//   disp_*              dispatch request from decode (valid/ready)
//   cdb_valid/tag/data  common data bus broadcast, snooped every cycle
//   alu_aluop/a/b       registered operation and operands to the ALU
//   alu_f               ALU result, combinational from alu_*
//   res_valid/ready     result handshake with the CDB arbiter
//   res_tag/res_data    destination ROB tag and value of the pending result

package lc3b_types;
  typedef enum logic [2:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra
  } lc3b_aluop;
endpackage

module alu_rs
  import lc3b_types::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  lc3b_aluop        disp_aluop,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             disp_qj_pend,
  input  logic             disp_qk_pend,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [15:0]      disp_vj,
  input  logic [15:0]      disp_vk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output lc3b_aluop        alu_aluop,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic [15:0]      alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [15:0]      res_data
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] qj_pend;
  logic [ENTRIES-1:0] qk_pend;
  lc3b_aluop          op_q   [ENTRIES];
  logic [TAG_W-1:0]   dest_q [ENTRIES];
  logic [TAG_W-1:0]   qj_q   [ENTRIES];
  logic [TAG_W-1:0]   qk_q   [ENTRIES];
  logic [15:0]        vj_q   [ENTRIES];
  logic [15:0]        vk_q   [ENTRIES];
  // older[i][j] is set when entry i was dispatched before entry j. Only rows of
  // busy entries are ever consulted, so the matrix needs no reset.
  logic [ENTRIES-1:0] older  [ENTRIES];

  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] sel_oh;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               any_ready;
  logic               disp_fire;
  logic               issue;
  logic               disp_j_hit;
  logic               disp_k_hit;

  always_comb begin
    ready    = busy & ~qj_pend & ~qk_pend;
    free_idx = '0;
    sel_oh   = '0;
    sel_idx  = '0;
    // Descending scan so the lowest-index free entry wins.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
    // An entry is selected when no other ready entry is older than it; the age
    // matrix is a total order over busy entries, so at most one bit survives.
    for (int i = 0; i < ENTRIES; i++) begin
      sel_oh[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && older[j][i]) sel_oh[i] = 1'b0;
      end
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    any_ready  = |ready;
    disp_ready = ~&busy;
    disp_fire  = disp_valid && disp_ready;
    issue      = any_ready && (!res_valid || res_ready);
    disp_j_hit = cdb_valid && disp_qj_pend && (cdb_tag == disp_qj);
    disp_k_hit = cdb_valid && disp_qk_pend && (cdb_tag == disp_qk);
  end

  assign res_data = alu_f;

  // Station -> exec slot boundary. The slot itself carries reset values because
  // the ALU inputs must be defined from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      res_valid <= 1'b0;
      alu_aluop <= alu_pass;
      alu_a     <= '0;
      alu_b     <= '0;
      res_tag   <= '0;
    end else if (flush) begin
      busy      <= '0;
      res_valid <= 1'b0;
    end else begin
      if (issue) begin
        busy[sel_idx] <= 1'b0;
        alu_aluop     <= op_q[sel_idx];
        alu_a         <= vj_q[sel_idx];
        alu_b         <= vk_q[sel_idx];
        res_tag       <= dest_q[sel_idx];
        res_valid     <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      // free_idx comes from the pre-edge busy bits, so it never aliases the
      // entry being issued this cycle.
      if (disp_fire) busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload, operand capture and age order. Validity is owned by busy,
  // so these registers are left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy[i] && cdb_valid) begin
        if (qj_pend[i] && (qj_q[i] == cdb_tag)) begin
          vj_q[i]    <= cdb_data;
          qj_pend[i] <= 1'b0;
        end
        if (qk_pend[i] && (qk_q[i] == cdb_tag)) begin
          vk_q[i]    <= cdb_data;
          qk_pend[i] <= 1'b0;
        end
      end
    end
    if (disp_fire) begin
      op_q[free_idx]    <= disp_aluop;
      dest_q[free_idx]  <= disp_dest;
      qj_q[free_idx]    <= disp_qj;
      qk_q[free_idx]    <= disp_qk;
      // A broadcast in the dispatch cycle would otherwise be missed, since the
      // entry is not yet busy for the snoop above.
      qj_pend[free_idx] <= disp_qj_pend && !disp_j_hit;
      qk_pend[free_idx] <= disp_qk_pend && !disp_k_hit;
      vj_q[free_idx]    <= disp_j_hit ? cdb_data : disp_vj;
      vk_q[free_idx]    <= disp_k_hit ? cdb_data : disp_vk;
      older[free_idx]   <= '0;
      for (int j = 0; j < ENTRIES; j++) begin
        older[j][free_idx] <= busy[j];
      end
    end
  end

endmodule
